// File: rtl/param_register_file.sv
// Multi-lane register file: two registered read ports, one lane-masked write port, clear sweep.
// Latency: 1 cycle on reads with write-first forwarding; a clear sweep holds busy for NUM_REGS cycles.
// Backpressure: none; writes and clear requests that arrive during a sweep are dropped.
module param_register_file #(
    parameter int DATA_W   = 512,
    parameter int NUM_REGS = 4,
    parameter int LANE_W   = 32,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int NLANES  = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_from_a_address,
    input  logic [ADDR_W-1:0] read_from_b_address,
    input  logic [ADDR_W-1:0] address_to_write,
    input  logic [DATA_W-1:0] data_to_write,
    input  logic              write_enable,
    input  logic [NLANES-1:0] write_lane_mask,
    input  logic              clear_request,
    output logic [DATA_W-1:0] data_from_a,
    output logic [DATA_W-1:0] data_from_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t                         state, state_nxt;
    logic [ADDR_W-1:0]              cnt, cnt_nxt;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem, mem_nxt;
    logic [NUM_REGS-1:0]            vld, vld_nxt;
    logic [DATA_W-1:0]              merged;
    logic                           wr_acc;

    // Sweep control: a clear request in IDLE wins over a simultaneous write.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        wr_acc    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_request) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    wr_acc = write_enable;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Post-edge image of the storage; reads index it directly to get write-first forwarding.
    always_comb begin
        merged = mem[address_to_write];
        for (int l = 0; l < NLANES; l++) begin
            if (write_lane_mask[l]) begin
                merged[l*LANE_W +: LANE_W] = data_to_write[l*LANE_W +: LANE_W];
            end
        end

        mem_nxt = mem;
        vld_nxt = vld;
        if (wr_acc) begin
            mem_nxt[address_to_write] = merged;
            if (|write_lane_mask) begin
                vld_nxt[address_to_write] = 1'b1;
            end
        end
        if (state == CLEAR) begin
            mem_nxt[cnt] = '0;
            vld_nxt[cnt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem         <= '0;
            vld         <= '0;
            data_from_a <= '0;
            data_from_b <= '0;
            valid_a     <= 1'b0;
            valid_b     <= 1'b0;
        end else begin
            mem         <= mem_nxt;
            vld         <= vld_nxt;
            data_from_a <= mem_nxt[read_from_a_address];
            data_from_b <= mem_nxt[read_from_b_address];
            valid_a     <= vld_nxt[read_from_a_address];
            valid_b     <= vld_nxt[read_from_b_address];
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: expected read results are queued when stimulus is
// driven and popped/compared one edge later.
module tb_param_register_file;

    localparam int DATA_W   = 512;
    localparam int NUM_REGS = 4;
    localparam int LANE_W   = 32;
    localparam int ADDR_W   = 2;
    localparam int NLANES   = 16;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] da;
        logic              va;
        logic [DATA_W-1:0] db;
        logic              vb;
        logic              bz;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] ra, rb, wa;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [NLANES-1:0] wm;
    logic              clr;
    logic [DATA_W-1:0] data_from_a, data_from_b;
    logic              valid_a, valid_b, busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [DATA_W-1:0] z, ones, a5, low1, r2p, p0, p3, p5, p6;

    param_register_file #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .LANE_W  (LANE_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .read_from_a_address(ra),
        .read_from_b_address(rb),
        .address_to_write   (wa),
        .data_to_write      (wd),
        .write_enable       (we),
        .write_lane_mask    (wm),
        .clear_request      (clr),
        .data_from_a        (data_from_a),
        .data_from_b        (data_from_b),
        .valid_a            (valid_a),
        .valid_b            (valid_b),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus, queue what the outputs must show after the edge, then compare.
    task automatic step(input string tag,
                        input logic [ADDR_W-1:0] s_ra, input logic [ADDR_W-1:0] s_rb,
                        input logic s_we, input logic [ADDR_W-1:0] s_wa,
                        input logic [DATA_W-1:0] s_wd, input logic [NLANES-1:0] s_wm,
                        input logic s_clr,
                        input logic [DATA_W-1:0] e_da, input logic e_va,
                        input logic [DATA_W-1:0] e_db, input logic e_vb, input logic e_bz);
        exp_t e;
        exp_t got;
        ra  = s_ra;
        rb  = s_rb;
        we  = s_we;
        wa  = s_wa;
        wd  = s_wd;
        wm  = s_wm;
        clr = s_clr;
        e.tag = tag;
        e.da  = e_da;
        e.va  = e_va;
        e.db  = e_db;
        e.vb  = e_vb;
        e.bz  = e_bz;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({got.tag, ".data_a"},  data_from_a, got.da);
        chk({got.tag, ".valid_a"}, DATA_W'(valid_a), DATA_W'(got.va));
        chk({got.tag, ".data_b"},  data_from_b, got.db);
        chk({got.tag, ".valid_b"}, DATA_W'(valid_b), DATA_W'(got.vb));
        chk({got.tag, ".busy"},    DATA_W'(busy), DATA_W'(got.bz));
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] s_ra, input logic [ADDR_W-1:0] s_rb,
                      input logic [DATA_W-1:0] e_da, input logic e_va,
                      input logic [DATA_W-1:0] e_db, input logic e_vb, input logic e_bz);
        step(tag, s_ra, s_rb, 1'b0, 2'd0, z, '0, 1'b0, e_da, e_va, e_db, e_vb, e_bz);
    endtask

    initial begin
        z    = '0;
        ones = '1;
        a5   = {64{8'hA5}};
        low1 = 512'hFFFF_FFFF;
        r2p  = {32'h0, {60{8'hA5}}};
        p0   = {16{32'h1111_1111}};
        p3   = {16{32'h3333_3333}};
        p5   = {16{32'h5A5A_0F0F}};
        p6   = {16{32'hC0DE_6666}};

        rst = 1'b1;
        ra = '0; rb = '0; wa = '0; wd = '0; we = 1'b0; wm = '0; clr = 1'b0;
        #2;
        chk("in_reset.data_a",  data_from_a, z);
        chk("in_reset.valid_b", DATA_W'(valid_b), z);
        chk("in_reset.busy",    DATA_W'(busy), z);
        @(negedge clk);
        rst = 1'b0;

        // Everything reads empty after reset.
        for (int i = 0; i < NUM_REGS; i++) begin
            rd("reset_read", ADDR_W'(i), ADDR_W'(NUM_REGS - 1 - i), z, 1'b0, z, 1'b0, 1'b0);
        end

        // Full-mask write, then both ports read it back.
        step("wr2_full", 2'd0, 2'd0, 1'b1, 2'd2, a5, '1, 1'b0, z, 1'b0, z, 1'b0, 1'b0);
        rd("rd2_both", 2'd2, 2'd2, a5, 1'b1, a5, 1'b1, 1'b0);

        // Single-lane write with same-cycle forwarding.
        step("wr1_lane0_fwd", 2'd1, 2'd0, 1'b1, 2'd1, ones, 16'h0001, 1'b0, low1, 1'b1, z, 1'b0, 1'b0);
        rd("rd1_rd2", 2'd1, 2'd2, low1, 1'b1, a5, 1'b1, 1'b0);
        // Top lane only, forwarded merge keeps the other 15 lanes.
        step("wr2_lane15_fwd", 2'd2, 2'd1, 1'b1, 2'd2, z, 16'h8000, 1'b0, r2p, 1'b1, low1, 1'b1, 1'b0);
        // All-zero mask changes neither data nor valid.
        step("wr3_nomask", 2'd3, 2'd3, 1'b1, 2'd3, ones, 16'h0000, 1'b0, z, 1'b0, z, 1'b0, 1'b0);

        step("wr0", 2'd0, 2'd3, 1'b1, 2'd0, p0, '1, 1'b0, p0, 1'b1, z, 1'b0, 1'b0);
        step("wr3", 2'd3, 2'd0, 1'b1, 2'd3, p3, '1, 1'b0, p3, 1'b1, p0, 1'b1, 1'b0);

        // Clear with a simultaneous write to reg 0: write dropped, sweep runs 4 cycles.
        step("clr_start", 2'd0, 2'd1, 1'b1, 2'd0, ones, '1, 1'b1, p0, 1'b1, low1, 1'b1, 1'b1);
        rd("sweep0", 2'd0, 2'd1, z, 1'b0, low1, 1'b1, 1'b1);
        rd("sweep1", 2'd1, 2'd2, z, 1'b0, r2p, 1'b1, 1'b1);
        rd("sweep2", 2'd2, 2'd3, z, 1'b0, p3, 1'b1, 1'b1);
        rd("sweep3", 2'd3, 2'd0, z, 1'b0, z, 1'b0, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd("post_clear", ADDR_W'(i), ADDR_W'(i), z, 1'b0, z, 1'b0, 1'b0);
        end

        // Writes and repeated clear requests during the sweep are ignored.
        step("wr3_again", 2'd3, 2'd3, 1'b1, 2'd3, p3, '1, 1'b0, p3, 1'b1, p3, 1'b1, 1'b0);
        step("clr2_start", 2'd3, 2'd0, 1'b0, 2'd0, z, '0, 1'b1, p3, 1'b1, z, 1'b0, 1'b1);
        rd("clr2_sw0", 2'd0, 2'd3, z, 1'b0, p3, 1'b1, 1'b1);
        step("clr2_sw1_wr3", 2'd3, 2'd3, 1'b1, 2'd3, ones, '1, 1'b1, p3, 1'b1, p3, 1'b1, 1'b1);
        step("clr2_sw2_clr", 2'd3, 2'd2, 1'b0, 2'd0, z, '0, 1'b1, p3, 1'b1, z, 1'b0, 1'b1);
        rd("clr2_sw3", 2'd3, 2'd3, z, 1'b0, z, 1'b0, 1'b0);
        rd("clr2_after", 2'd3, 2'd3, z, 1'b0, z, 1'b0, 1'b0);

        // Reset in the middle of a sweep.
        step("wr1_p5", 2'd1, 2'd1, 1'b1, 2'd1, p5, '1, 1'b0, p5, 1'b1, p5, 1'b1, 1'b0);
        step("wr2_p6", 2'd2, 2'd1, 1'b1, 2'd2, p6, '1, 1'b0, p6, 1'b1, p5, 1'b1, 1'b0);
        step("clr3_start", 2'd1, 2'd2, 1'b0, 2'd0, z, '0, 1'b1, p5, 1'b1, p6, 1'b1, 1'b1);
        rd("clr3_sw0", 2'd1, 2'd2, p5, 1'b1, p6, 1'b1, 1'b1);
        rd("clr3_sw1", 2'd2, 2'd1, p6, 1'b1, z, 1'b0, 1'b1);
        ra = 2'd2;
        rb = 2'd2;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.data_a",  data_from_a, z);
        chk("mid_rst.valid_a", DATA_W'(valid_a), z);
        chk("mid_rst.data_b",  data_from_b, z);
        chk("mid_rst.valid_b", DATA_W'(valid_b), z);
        chk("mid_rst.busy",    DATA_W'(busy), z);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step("post_rst_wr1", 2'd2, 2'd1, 1'b1, 2'd1, p6, '1, 1'b0, z, 1'b0, p6, 1'b1, 1'b0);
        rd("post_rst_rd", 2'd1, 2'd3, p6, 1'b1, z, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 512, bits per register; a multiple of LANE_W.
- NUM_REGS, 4, register count; a power of two, at least 2.
- LANE_W, 32, bits per write lane.
- ADDR_W, $clog2(NUM_REGS) (2), address width; derived, not overridden.
- NLANES, DATA_W/LANE_W (16), lane count; derived.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- read_from_a_address, in, ADDR_W, port A read address.
- read_from_b_address, in, ADDR_W, port B read address.
- address_to_write, in, ADDR_W, write address.
- data_to_write, in, DATA_W, write data.
- write_enable, in, 1, write request.
- write_lane_mask, in, NLANES, per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W].
- clear_request, in, 1, starts a clear sweep.
- data_from_a, out, DATA_W, registered port A read data.
- data_from_b, out, DATA_W, registered port B read data.
- valid_a, out, 1, port A register was written since last reset/clear.
- valid_b, out, 1, same, port B.
- busy, out, 1, clear sweep in progress.

Function
REQ-003 Storage SHALL be NUM_REGS registers of DATA_W bits, each with a valid bit.
REQ-004 An accepted write SHALL update only lanes whose mask bit is 1; other lanes hold.
REQ-005 A write SHALL be accepted when write_enable=1, FSM is IDLE and clear_request=0.
REQ-006 An accepted write with a nonzero mask SHALL set that register's valid bit; an all-zero mask changes nothing.
REQ-007 Reads SHALL have 1-cycle latency: the address sampled at edge N drives data_from_x/valid_x after edge N, held until the next edge.
REQ-008 A read of the address being written by an accepted write in the same cycle SHALL return the merged post-write value and valid=1 (write-first forwarding).
REQ-009 Ports A and B SHALL be independent; the same address on both SHALL return identical data.
REQ-010 FSM SHALL have two states: IDLE and CLEAR.
REQ-011 In IDLE, clear_request=1 SHALL go to CLEAR at the next edge, load the sweep counter with 0 and set busy=1; a simultaneous write is dropped.
REQ-012 In CLEAR, each cycle SHALL zero register[counter] and its valid bit, then increment the counter.
REQ-013 After clearing index NUM_REGS-1, the FSM SHALL return to IDLE with busy=0; a sweep takes exactly NUM_REGS cycles of busy=1.
REQ-014 In CLEAR, writes and clear_request SHALL be ignored; reads continue to return current contents, with forwarding of the same-cycle clear (data 0, valid 0).
REQ-015 The sweep counter SHALL be ADDR_W bits and SHALL not wrap into a second pass.

Reset
REQ-016 rst=1 SHALL asynchronously zero all registers and valid bits, force IDLE, counter=0, busy=0, data_from_a=data_from_b=0, valid_a=valid_b=0.
REQ-017 rst asserted mid-sweep SHALL abort the sweep; after release the block is IDLE with all registers zero.
REQ-018 The first edge after rst deassertion SHALL accept writes normally.

Verification
REQ-019 Reset, then read all addresses on both ports -> data 0, valid 0, busy 0.
REQ-020 Write addr 2, data all 0xA5 bytes, full mask; next cycle read A=2, B=2 -> both 0xA5..A5, valid 1, one cycle after the read address is applied.
REQ-021 Reg 1 holds 0; write addr 1, data 0xFF..FF, mask 16'h0001, while reading A=1 in the same cycle -> next cycle data_from_a = 0x00..00FFFFFFFF, valid_a=1 (forwarding and lane mask).
REQ-022 Write regs 0-3, then pulse clear_request together with a write to reg 0 -> busy high exactly 4 cycles; write dropped; afterwards all reads return 0, valid 0.
REQ-023 Pulse clear_request; in the 2nd busy cycle issue a write to reg 3 -> write ignored; reg 3 reads 0 after the sweep; a second clear_request during busy does not extend busy.
REQ-024 Assert rst during the 3rd sweep cycle -> outputs 0 immediately without waiting for clk; busy 0; a write on the first edge after release is read back correctly.
